composer_sequencer: RTL

COMPOSER_SEQUENCER -- requirements
Module: composer_sequencer

---
 rtl/composer_pkg.sv | 20 ++
 rtl/note_buffer.sv | 21 ++
 rtl/composer_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/composer_pkg.sv
// composer_pkg: shared state encodings and playback source selector for the composer sequencer.
package composer_pkg;
    typedef enum logic [3:0] {
        MENU        = 4'd0,
        START       = 4'd1,
        SELECT_MODE = 4'd2,
        SELECT_SONG = 4'd3,
        EDIT        = 4'd4,
        DELETE      = 4'd5,
        INSERT      = 4'd6,
        MAKE_SONG   = 4'd7,
        PLAY_FETCH  = 4'd8,
        PLAY_NOTE   = 4'd9,
        PLAY_WAIT   = 4'd10
    } state_e;
    typedef enum logic {
        SRC_ROM = 1'b0,
        SRC_BUF = 1'b1
    } src_e;
endpackage

// File: rtl/note_buffer.sv
// note_buffer: DEPTH x NOTE_W user note store, one write port, registered one-cycle read.
module note_buffer #(
    parameter int NOTE_W = 5,
    parameter int DEPTH  = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [NOTE_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [NOTE_W-1:0] rdata_o
);
    logic [NOTE_W-1:0] mem_q [DEPTH];
    logic [NOTE_W-1:0] rdata_q;
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_q <= mem_q[raddr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/composer_sequencer.sv
// composer_sequencer: menu/edit/playback FSM that plays either a preset ROM song or a user-built buffer.
module composer_sequencer
    import composer_pkg::*;
#(
    parameter int NOTE_W         = 5,
    parameter int DEPTH          = 32,
    parameter int TICKS_PER_NOTE = 12500000,
    parameter int INS_HOLD       = 4,
    parameter int CNT_W          = $clog2(DEPTH+1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              restart,
    input  logic              make_my_own,
    input  logic              insert,
    input  logic              delete,
    input  logic              end_insert,
    input  logic              play,
    input  logic              play_again,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [NOTE_W-1:0] rom_note,
    input  logic [CNT_W-1:0]  rom_len,
    output logic [CNT_W-1:0]  rom_addr,
    output logic [3:0]        state_code,
    output logic [CNT_W-1:0]  count,
    output logic              is_full,
    output logic              is_empty,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_valid,
    output logic              play_done
);
    localparam int AW   = $clog2(DEPTH);
    localparam int TMAX = TICKS_PER_NOTE > INS_HOLD ? TICKS_PER_NOTE : INS_HOLD;
    localparam int TW   = $clog2(TMAX+1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e            state_q, state_d;
    src_e              src_q, src_d;
    logic [CNT_W-1:0]  count_q, count_d, idx_q, idx_d, len_q, len_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [NOTE_W-1:0] note_q, note_d, buf_rdata, rd_note;
    logic              valid_q, valid_d, done_q, done_d, we;

    note_buffer #(.NOTE_W(NOTE_W), .DEPTH(DEPTH)) u_buf (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (note_in),
        .raddr_i (idx_q[AW-1:0]),
        .rdata_o (buf_rdata)
    );

    assign is_full  = count_q == CNT_W'(DEPTH);
    assign is_empty = count_q == '0;
    assign rd_note  = src_q == SRC_ROM ? rom_note : buf_rdata;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        count_d = count_q;
        idx_d   = idx_q;
        len_d   = len_q;
        tick_d  = tick_q;
        note_d  = note_q;
        valid_d = 1'b0;
        we      = 1'b0;
        if (restart && state_q != MENU) begin
            state_d = START;
            count_d = '0;
            idx_d   = '0;
            tick_d  = '0;
        end else begin
            case (state_q)
                MENU:        if (start) state_d = START;
                START:       state_d = SELECT_MODE;
                SELECT_MODE: state_d = make_my_own ? EDIT : SELECT_SONG;
                SELECT_SONG: if (play) begin
                    state_d = PLAY_FETCH;
                    src_d   = SRC_ROM;
                end
                EDIT: begin
                    if (delete && !is_empty) begin
                        state_d = DELETE;
                        count_d = count_q - ONE;
                    end else if (insert && !is_full) begin
                        state_d = INSERT;
                        we      = 1'b1;
                        count_d = count_q + ONE;
                        tick_d  = '0;
                    end else if (end_insert || is_full) begin
                        state_d = MAKE_SONG;
                    end
                end
                DELETE:      state_d = EDIT;
                INSERT: begin
                    tick_d  = tick_q == TW'(INS_HOLD-1) ? '0 : tick_q + TW'(1);
                    state_d = tick_q == TW'(INS_HOLD-1) ? EDIT : INSERT;
                end
                MAKE_SONG:   if (play) begin
                    state_d = PLAY_FETCH;
                    src_d   = SRC_BUF;
                end
                PLAY_FETCH: begin
                    tick_d  = '0;
                    state_d = len_q == '0 ? PLAY_WAIT : PLAY_NOTE;
                end
                // tick 0 latches the read data; ticks 1..TICKS_PER_NOTE sound it
                PLAY_NOTE: begin
                    if (tick_q == TW'(TICKS_PER_NOTE)) begin
                        tick_d = '0;
                        if (idx_q + ONE < len_q) begin
                            state_d = PLAY_FETCH;
                            idx_d   = idx_q + ONE;
                        end else begin
                            state_d = PLAY_WAIT;
                        end
                    end else begin
                        tick_d  = tick_q + TW'(1);
                        valid_d = 1'b1;
                        if (tick_q == '0) note_d = rd_note;
                    end
                end
                PLAY_WAIT:   if (play_again) state_d = PLAY_FETCH;
                default:     state_d = MENU;
            endcase
            if (state_d == PLAY_FETCH && state_q != PLAY_NOTE) begin
                idx_d = '0;
                len_d = src_d == SRC_ROM ? rom_len : count_q;
            end
        end
        done_d = state_d == PLAY_WAIT && state_q != PLAY_WAIT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MENU;
            src_q   <= SRC_ROM;
            count_q <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            tick_q  <= '0;
            note_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            tick_q  <= tick_d;
            note_q  <= note_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign state_code = state_q;
    assign count      = count_q;
    assign rom_addr   = idx_q;
    assign note_out   = note_q;
    assign note_valid = valid_q;
    assign play_done  = done_q;
endmodule
